tc_ram_dp: RTL and testbench
============================

# tc_ram_dp

Parametrised dual-port word RAM succeeding the single-port combinational-read RAM component. Port A reads and writes with per-64-bit-lane write enables; port B is read-only. Both ports have registered, one-cycle read latency with a valid strobe. Reset clears the array with a counted sweep, one word per cycle, instead of a single-cycle bulk clear. Sits between the CPU data path and bus/debug readers that need concurrent access.

## Interface
Parameters:
- WORD_WIDTH, 256, bits per word; legal values 8, 16, 32, 64, 128, 256.
- WORD_COUNT, 256, number of words; legal range 2..65536.
- LANES (localparam), WORD_WIDTH/64 when WORD_WIDTH >= 64, else 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- busy  out  1  high while the reset/clear sweep is active; both ports ignore requests while high.
- a_load  in  1  port A read request.
- a_save  in  1  port A write request.
- a_addr  in  32  port A word address.
- a_lane_en  in  LANES  port A per-lane write enable; lane k covers bits [64k+63:64k].
- a_wdata  in  WORD_WIDTH  port A write data.
- a_rdata  out  WORD_WIDTH  port A read data, registered.
- a_rvalid  out  1  one-cycle strobe marking new a_rdata.
- b_load  in  1  port B read request.
- b_addr  in  32  port B word address.
- b_rdata  out  WORD_WIDTH  port B read data, registered.
- b_rvalid  out  1  one-cycle strobe marking new b_rdata.

## Operation
- The controller has two states, CLEAR and READY. rst=1 forces CLEAR at the next edge and sets the sweep counter to 0.
- In CLEAR with rst=0, the block writes zero to mem[counter] and increments the counter each cycle. After word WORD_COUNT-1 is cleared, it moves to READY. busy = (state==CLEAR).
- While in CLEAR:
  - Load and save requests are dropped, not queued.
  - rvalid outputs stay 0.
  - rdata outputs hold 0.
- In READY:
  - a_save=1 writes a_wdata into the lanes of mem[a_addr] selected by a_lane_en. Disabled lanes keep their old contents.
  - With a_lane_en all zero, no write occurs.
  - When WORD_WIDTH < 64, a_lane_en[0] gates the whole word.
- A read (a_load or b_load) captures mem[addr] into rdata. rvalid is 1 in the following cycle only.
- Without a load, rdata holds its last value and rvalid is 0.
- Any address >= WORD_COUNT:
  - A write to it is discarded.
  - A read from it returns 0 with rvalid=1.
- Collisions use read-first ordering:
  - a_load and a_save to the same address in the same cycle: a_rdata returns the pre-write data.
  - b_load to the address port A writes in the same cycle: b_rdata returns the pre-write data.
  - The new data is visible to any read issued one cycle later.

## Timing
- Reset values: busy=1 from the edge after rst is sampled high (with the clear feature); a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0.
- Clear duration: busy deasserts exactly WORD_COUNT edges after the first edge with rst=0.
- Asserting rst mid-sweep restarts the sweep at counter 0.
- Read latency is 1 cycle, request edge to data. Back-to-back loads produce one result per cycle.
- Write latency is 0 cycles: the array updates on the request edge.
- Counter width is clog2(WORD_COUNT)+1, and the counter never wraps.
- Address compare uses all 32 bits.

## Configuration
- TC_RAM_DP_CLEAR_SWEEP_EN defined:
  - Reset behaves as described above, with CLEAR state, sweep and busy.
- TC_RAM_DP_CLEAR_SWEEP_EN undefined:
  - Reset zeroes only the output registers and goes to READY at the next edge.
  - Array contents survive reset; contents at power-up are unspecified.
  - busy is tied to 0.
  - The CLEAR state and the sweep counter are not built.

## Test plan
- Reset sweep: WORD_COUNT=16, rst for 2 cycles, then released -> busy high for exactly 16 cycles; subsequent reads of addresses 0..15 return 0 with rvalid=1.
- Lane write: WORD_WIDTH=256; write all ones to addr 3; then write a_wdata=0 with a_lane_en=4'b0101 -> read returns lanes 1 and 3 all ones, lanes 0 and 2 zero.
- Read-first collision: mem[5]=0xAA; same cycle a_save 0xBB to 5, a_load 5, b_load 5 -> both rdata=0xAA; next-cycle reads return 0xBB.
- Out of range: WORD_COUNT=16, write 0x77 to addr 16, then read addr 16 -> rdata=0, rvalid=1; addr 0 unchanged.
- Mid-sweep reset: assert rst at sweep count 7 -> sweep restarts; busy lasts WORD_COUNT cycles after release; a_load issued during busy produces no rvalid.
- Macro undefined: write 0x55 to addr 2, pulse rst -> busy stays 0; outputs become 0; reading addr 2 returns 0x55.

Source files
------------

// File: rtl/tc_ram_dp.sv
// Dual-port word RAM: port A read/write with 64-bit lane enables, port B read-only; registered reads.
// TC_RAM_DP_CLEAR_SWEEP_EN enables the one-word-per-cycle reset clear sweep and busy flag.
module tc_ram_dp #(
   parameter int WORD_WIDTH = 256,
   parameter int WORD_COUNT = 256,
   localparam int LANES = (WORD_WIDTH >= 64) ? WORD_WIDTH / 64 : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  busy,
   input  logic                  a_load,
   input  logic                  a_save,
   input  logic [31:0]           a_addr,
   input  logic [LANES-1:0]      a_lane_en,
   input  logic [WORD_WIDTH-1:0] a_wdata,
   output logic [WORD_WIDTH-1:0] a_rdata,
   output logic                  a_rvalid,
   input  logic                  b_load,
   input  logic [31:0]           b_addr,
   output logic [WORD_WIDTH-1:0] b_rdata,
   output logic                  b_rvalid
);
   localparam int AW = $clog2(WORD_COUNT);
   localparam int CW = AW + 1;

   logic [WORD_WIDTH-1:0] mem_q [WORD_COUNT];
   logic                  ready;
   logic                  clr_we;
   logic [AW-1:0]         clr_idx;

`ifdef TC_RAM_DP_CLEAR_SWEEP_EN
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(WORD_COUNT - 1)) state_d = ST_READY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready   = (state_q == ST_READY);
   assign busy    = (state_q == ST_CLEAR);
   assign clr_we  = busy & ~rst;
   assign clr_idx = cnt_q[AW-1:0];
`else
   assign ready   = 1'b1;
   assign busy    = 1'b0;
   assign clr_we  = 1'b0;
   assign clr_idx = '0;
`endif

   // Upper address bits take part in the range check, so aliases never hit the array.
   logic          a_in, b_in;
   logic [AW-1:0] a_idx, b_idx;
   logic          a_rd, a_wr, b_rd;

   assign a_in  = (a_addr < 32'(WORD_COUNT));
   assign b_in  = (b_addr < 32'(WORD_COUNT));
   assign a_idx = a_addr[AW-1:0];
   assign b_idx = b_addr[AW-1:0];
   assign a_rd  = ready & ~rst & a_load;
   assign b_rd  = ready & ~rst & b_load;
   assign a_wr  = ready & ~rst & a_save & a_in;

   logic [WORD_WIDTH-1:0] wmask;
   generate
      if (WORD_WIDTH >= 64) begin : g_lanes
         for (genvar k = 0; k < LANES; k++) begin : g_l
            assign wmask[64*k +: 64] = {64{a_lane_en[k]}};
         end
      end else begin : g_narrow
         assign wmask = {WORD_WIDTH{a_lane_en[0]}};
      end
   endgenerate

   // Non-blocking array update gives read-first ordering for same-cycle reads.
   always_ff @(posedge clk) begin
      if (clr_we)
         mem_q[clr_idx] <= '0;
      else if (a_wr)
         mem_q[a_idx] <= (mem_q[a_idx] & ~wmask) | (a_wdata & wmask);
   end

   logic [WORD_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic                  a_rvalid_q, b_rvalid_q;

   always_comb begin
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      if (a_rd) a_rdata_d = a_in ? mem_q[a_idx] : '0;
      if (b_rd) b_rdata_d = b_in ? mem_q[b_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
         a_rvalid_q <= a_rd;
         b_rvalid_q <= b_rd;
      end
   end

   assign a_rdata  = a_rdata_q;
   assign a_rvalid = a_rvalid_q;
   assign b_rdata  = b_rdata_q;
   assign b_rvalid = b_rvalid_q;
endmodule

// File: tb/tb_tc_ram_dp.sv
// Directed plus random bench for tc_ram_dp against an array-based reference model.
module tb_tc_ram_dp;
   localparam int WW = 256;
   localparam int WC = 16;
   localparam int LN = WW / 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          busy;
   logic          a_load = 1'b0, a_save = 1'b0, b_load = 1'b0;
   logic [31:0]   a_addr = '0, b_addr = '0;
   logic [LN-1:0] a_lane_en = '0;
   logic [WW-1:0] a_wdata = '0;
   logic [WW-1:0] a_rdata, b_rdata;
   logic          a_rvalid, b_rvalid;

   int checks = 0;
   int failures = 0;

   logic [WW-1:0] mdl [WC];
   logic [WW-1:0] last_a = '0, last_b = '0;

   tc_ram_dp #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
      .clk(clk), .rst(rst), .busy(busy),
      .a_load(a_load), .a_save(a_save), .a_addr(a_addr), .a_lane_en(a_lane_en),
      .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_load(b_load), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] rd_model(input logic [31:0] addr);
      return (addr < WC) ? mdl[addr[3:0]] : '0;
   endfunction

   // One cycle of traffic; expected reads taken from the model before the write lands.
   task automatic op(input bit al, input bit as, input logic [31:0] aa, input logic [LN-1:0] le,
                     input logic [WW-1:0] wd, input bit bl, input logic [31:0] ba);
      logic [WW-1:0] ea, eb;
      a_load = al; a_save = as; a_addr = aa; a_lane_en = le; a_wdata = wd;
      b_load = bl; b_addr = ba;
      ea = al ? rd_model(aa) : last_a;
      eb = bl ? rd_model(ba) : last_b;
      if (as && aa < WC)
         for (int k = 0; k < LN; k++)
            if (le[k]) mdl[aa[3:0]][64*k +: 64] = wd[64*k +: 64];
      cyc();
      a_load = 1'b0; a_save = 1'b0; b_load = 1'b0;
      chk("a_rvalid", WW'(a_rvalid), WW'(al));
      chk("a_rdata", a_rdata, ea);
      chk("b_rvalid", WW'(b_rvalid), WW'(bl));
      chk("b_rdata", b_rdata, eb);
      last_a = ea; last_b = eb;
   endtask

`ifdef TC_RAM_DP_CLEAR_SWEEP_EN
   // Counts edges until busy drops, with loads held high to confirm they are dropped.
   task automatic sweep(input string tag, input int stop_at);
      int n;
      n = 0;
      a_load = 1'b1; b_load = 1'b1; a_addr = 0; b_addr = 1;
      do begin
         cyc();
         n++;
         chk({tag, "_rv"}, WW'({a_rvalid, b_rvalid}), '0);
      end while (busy && n < 100 && n != stop_at);
      a_load = 1'b0; b_load = 1'b0;
      if (stop_at < 0) chk({tag, "_len"}, WW'(n), WW'(WC));
   endtask
`endif

   initial begin
      logic [WW-1:0] r;
      for (int i = 0; i < WC; i++) mdl[i] = '0;
      rst = 1'b1;
      cyc(); cyc();
      chk("rst_a_rdata", a_rdata, '0);
      chk("rst_b_rdata", b_rdata, '0);
      chk("rst_rvalid", WW'({a_rvalid, b_rvalid}), '0);
`ifdef TC_RAM_DP_CLEAR_SWEEP_EN
      chk("rst_busy", WW'(busy), WW'(1));
      rst = 1'b0;
      sweep("sweep_mid", 7);
      chk("mid_busy", WW'(busy), WW'(1));
      rst = 1'b1;
      cyc();
      chk("mid_rst_busy", WW'(busy), WW'(1));
      rst = 1'b0;
      sweep("sweep", -1);
      chk("ready_busy", WW'(busy), '0);
      for (int i = 0; i < WC; i++) op(1, 0, i, '0, '0, 1, WC - 1 - i);
`else
      chk("rst_busy", WW'(busy), '0);
      rst = 1'b0;
      cyc();
      chk("ready_busy", WW'(busy), '0);
      // Array is uninitialised without the sweep; give every word a known value first.
      for (int i = 0; i < WC; i++) op(0, 1, i, '1, {8{$urandom}}, 0, 0);
      for (int i = 0; i < WC; i++) op(1, 0, i, '0, '0, 1, WC - 1 - i);
`endif

      // Lane write: lanes 1 and 3 keep the ones, lanes 0 and 2 take zero.
      op(0, 1, 3, '1, '1, 0, 0);
      op(0, 1, 3, 4'b0101, '0, 0, 0);
      op(1, 0, 3, '0, '0, 1, 3);
      r = {{64{1'b1}}, 64'h0, {64{1'b1}}, 64'h0};
      chk("lane_a", a_rdata, r);
      chk("lane_b", b_rdata, r);
      op(0, 1, 3, '0, '1, 0, 0);
      op(1, 0, 3, '0, '0, 0, 0);
      chk("lane_none", a_rdata, r);

      // Read-first collision.
      op(0, 1, 5, '1, WW'(8'hAA), 0, 0);
      op(1, 1, 5, '1, WW'(8'hBB), 1, 5);
      chk("coll_a", a_rdata, WW'(8'hAA));
      chk("coll_b", b_rdata, WW'(8'hAA));
      op(1, 0, 5, '0, '0, 1, 5);
      chk("coll_next_a", a_rdata, WW'(8'hBB));
      chk("coll_next_b", b_rdata, WW'(8'hBB));

      // Out of range, including an alias of address 0 via upper bits.
      op(0, 1, 16, '1, WW'(8'h77), 0, 0);
      op(0, 1, 32'h8000_0000, '1, WW'(8'h77), 0, 0);
      op(1, 0, 16, '0, '0, 1, 0);
      chk("oor_a", a_rdata, '0);
      chk("oor_rv", WW'(a_rvalid), WW'(1));

      // Back-to-back and idle hold.
      op(1, 0, 5, '0, '0, 0, 0);
      op(0, 0, 0, '0, '0, 0, 0);
      chk("hold_a", a_rdata, WW'(8'hBB));

      for (int i = 0; i < 200; i++)
         op($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 19),
            LN'($urandom_range(0, 15)), {8{$urandom}},
            $urandom_range(0, 1), $urandom_range(0, 19));

      // Reset pulse with data stored at address 2.
      op(0, 1, 2, '1, WW'(8'h55), 0, 0);
      op(1, 0, 2, '0, '0, 1, 2);
      rst = 1'b1;
      cyc();
      chk("rst2_out", a_rdata | b_rdata, '0);
      chk("rst2_rv", WW'({a_rvalid, b_rvalid}), '0);
      last_a = '0; last_b = '0;
`ifdef TC_RAM_DP_CLEAR_SWEEP_EN
      chk("rst2_busy", WW'(busy), WW'(1));
      rst = 1'b0;
      for (int i = 0; i < WC; i++) mdl[i] = '0;
      sweep("sweep2", -1);
      op(1, 0, 2, '0, '0, 1, 2);
      chk("rst2_clr", a_rdata, '0);
`else
      chk("rst2_busy", WW'(busy), '0);
      rst = 1'b0;
      op(1, 0, 2, '0, '0, 1, 2);
      chk("rst2_keep", a_rdata, WW'(8'h55));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
